// File: rtl/rtc_pkg.sv
// Shared RTC constants: mode encodings, BCD digit limits and a BCD increment helper.
// The alarm edit modes exist only when RTC_ALARM_EN is defined.
package rtc_pkg;

  localparam logic [2:0] MODE_RUN    = 3'd0;
  localparam logic [2:0] MODE_SET_HH = 3'd1;
  localparam logic [2:0] MODE_SET_MM = 3'd2;
  localparam logic [2:0] MODE_SET_SS = 3'd3;
`ifdef RTC_ALARM_EN
  localparam logic [2:0] MODE_SET_AH = 3'd4;
  localparam logic [2:0] MODE_SET_AM = 3'd5;
`endif

  localparam int unsigned UNITS_MAX = 9;
  localparam int unsigned TENS_MAX  = 5;
  localparam int unsigned HR_MAX    = 23;
  localparam int unsigned MIN_MAX   = TENS_MAX * 10 + UNITS_MAX;

  // Each field is a two-digit BCD byte {tens, units}.
  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
  } rtc_time_t;

  function automatic int unsigned bcd_val(input logic [7:0] v);
    return {28'd0, v[7:4]} * 32'd10 + {28'd0, v[3:0]};
  endfunction

  // Fields never exceed their limit, so wrapping at the limit keeps them valid BCD.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int unsigned max_val);
    if (bcd_val(v) == max_val) begin
      return 8'h00;
    end else if (v[3:0] == 4'(UNITS_MAX)) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

endpackage

// File: rtl/rtc_time_controller_if.sv
// Button and display bundle of the RTC; master drives the buttons, slave is the clock itself.
interface rtc_time_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] sec_u;
  logic [2:0] sec_t;
  logic [3:0] min_u;
  logic [2:0] min_t;
  logic [3:0] hr_u;
  logic [1:0] hr_t;
  logic [2:0] mode;
  logic       blink;
  logic       alarm;

  modport master (
    output btn_mode, btn_inc,
    input  sec_u, sec_t, min_u, min_t, hr_u, hr_t, mode, blink, alarm
  );

  modport slave (
    input  btn_mode, btn_inc,
    output sec_u, sec_t, min_u, min_t, hr_u, hr_t, mode, blink, alarm
  );
endinterface

// File: rtl/rtc_prescaler.sv
// One-second tick generator: pulses tick for one cycle every DIV cycles; hold parks it at 0.
module rtc_prescaler #(
  parameter int unsigned DIV = 50000000
) (
  input  logic clk,
  input  logic aclr,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !hold && (cnt_q == CntLast);
    cnt_d = (hold || tick) ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_time_controller.sv
// Two-button BCD real-time clock with RUN and field-set modes and an edit blink strobe.
// Defining RTC_ALARM_EN adds alarm hour/minute edit modes and the alarm output.
module rtc_time_controller
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec_u,
  output logic [2:0] sec_t,
  output logic [3:0] min_u,
  output logic [2:0] min_t,
  output logic [3:0] hr_u,
  output logic [1:0] hr_t,
  output logic [2:0] mode,
  output logic       blink,
  output logic       alarm
);

  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  logic              btn_mode_q, btn_inc_q;
  logic              mode_ev, inc_ev, tick, hold;
  logic [2:0]        state_q, state_d;
  rtc_time_t         time_q, time_d;
  logic              blink_q, blink_d;
  logic [BlinkW-1:0] bcnt_q, bcnt_d;

  // A mode press wins over a simultaneous inc press, which is dropped.
  assign mode_ev = btn_mode & ~btn_mode_q;
  assign inc_ev  = btn_inc & ~btn_inc_q & ~mode_ev;
  assign hold    = (state_q != MODE_RUN);

  rtc_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .aclr (aclr),
    .hold (hold),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    if (mode_ev) begin
      case (state_q)
        MODE_RUN:    state_d = MODE_SET_HH;
        MODE_SET_HH: state_d = MODE_SET_MM;
        MODE_SET_MM: state_d = MODE_SET_SS;
`ifdef RTC_ALARM_EN
        MODE_SET_SS: state_d = MODE_SET_AH;
        MODE_SET_AH: state_d = MODE_SET_AM;
`endif
        default:     state_d = MODE_RUN;
      endcase
    end
  end

  always_comb begin
    time_d = time_q;
    case (state_q)
      MODE_RUN: begin
        if (tick) begin
          time_d.sec = bcd_inc(time_q.sec, MIN_MAX);
          if (bcd_val(time_q.sec) == MIN_MAX) begin
            time_d.min = bcd_inc(time_q.min, MIN_MAX);
            if (bcd_val(time_q.min) == MIN_MAX) time_d.hr = bcd_inc(time_q.hr, HR_MAX);
          end
        end
      end
      MODE_SET_HH: if (inc_ev) time_d.hr = bcd_inc(time_q.hr, HR_MAX);
      MODE_SET_MM: if (inc_ev) time_d.min = bcd_inc(time_q.min, MIN_MAX);
      MODE_SET_SS: if (inc_ev) time_d.sec = 8'h00;
      default: ;
    endcase
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if ((state_d != state_q) || (state_q == MODE_RUN)) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else if (bcnt_q == BlinkLast) begin
      bcnt_d  = '0;
      blink_d = ~blink_q;
    end else begin
      bcnt_d  = bcnt_q + BlinkW'(1);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
      state_q    <= MODE_RUN;
      time_q     <= '0;
      blink_q    <= 1'b0;
      bcnt_q     <= '0;
    end else begin
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
      state_q    <= state_d;
      time_q     <= time_d;
      blink_q    <= blink_d;
      bcnt_q     <= bcnt_d;
    end
  end

`ifdef RTC_ALARM_EN
  logic [7:0] al_hr_q, al_hr_d, al_min_q, al_min_d;
  logic       armed_q, armed_d, silenced_q, silenced_d, alarm_act;

  assign alarm_act = (state_q == MODE_RUN) && armed_q && !silenced_q &&
                     (time_q.hr == al_hr_q) && (time_q.min == al_min_q);

  always_comb begin
    al_hr_d    = al_hr_q;
    al_min_d   = al_min_q;
    armed_d    = armed_q | ((state_q == MODE_SET_AM) & mode_ev);
    silenced_d = silenced_q;
    if ((state_q == MODE_SET_AH) && inc_ev) al_hr_d = bcd_inc(al_hr_q, HR_MAX);
    if ((state_q == MODE_SET_AM) && inc_ev) al_min_d = bcd_inc(al_min_q, MIN_MAX);
    // Silence lasts until the minute moves on.
    if (time_d.min != time_q.min) silenced_d = 1'b0;
    else if (inc_ev && alarm_act) silenced_d = 1'b1;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      al_hr_q    <= 8'h00;
      al_min_q   <= 8'h00;
      armed_q    <= 1'b0;
      silenced_q <= 1'b0;
    end else begin
      al_hr_q    <= al_hr_d;
      al_min_q   <= al_min_d;
      armed_q    <= armed_d;
      silenced_q <= silenced_d;
    end
  end

  assign alarm = alarm_act;
`else
  assign alarm = 1'b0;
`endif

  assign sec_u = time_q.sec[3:0];
  assign sec_t = time_q.sec[6:4];
  assign min_u = time_q.min[3:0];
  assign min_t = time_q.min[6:4];
  assign hr_u  = time_q.hr[3:0];
  assign hr_t  = time_q.hr[5:4];
  assign mode  = state_q;
  assign blink = blink_q;

endmodule

// File: tb/tb_rtc_time_controller.sv
// Bench for rtc_time_controller: seconds-of-day reference model checked every cycle,
// directed scenarios with literal expectations, then randomized button/reset traffic.
module tb_rtc_time_controller;

  localparam int unsigned TD = 4;
  localparam int unsigned BD = 3;
`ifdef RTC_ALARM_EN
  localparam bit AlarmEn = 1'b1;
`else
  localparam bit AlarmEn = 1'b0;
`endif
  localparam int NSt = AlarmEn ? 6 : 4;

  logic clk = 1'b0;
  logic aclr;
  rtc_time_controller_if bus ();

  rtc_time_controller #(
    .TICK_DIV  (TD),
    .BLINK_DIV (BD)
  ) dut (
    .clk      (clk),
    .aclr     (aclr),
    .btn_mode (bus.btn_mode),
    .btn_inc  (bus.btn_inc),
    .sec_u    (bus.sec_u),
    .sec_t    (bus.sec_t),
    .min_u    (bus.min_u),
    .min_t    (bus.min_t),
    .hr_u     (bus.hr_u),
    .hr_t     (bus.hr_t),
    .mode     (bus.mode),
    .blink    (bus.blink),
    .alarm    (bus.alarm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: time as seconds of day, mode as 0..5 (RUN, HH, MM, SS, AH, AM).
  int m_st, m_t, m_ah, m_am, m_run_cyc, m_set_cyc, m_blink;
  bit m_armed, m_sil, m_pm, m_pi;

  function automatic bit model_alarm();
    return AlarmEn && (m_st == 0) && m_armed && !m_sil &&
           (m_t / 3600 == m_ah) && ((m_t / 60) % 60 == m_am);
  endfunction

  task automatic model_step();
    bit mev, iev, al_now;
    int h, mi, s, old_min;
    if (aclr) begin
      m_st = 0; m_t = 0; m_ah = 0; m_am = 0; m_run_cyc = 0; m_set_cyc = 0; m_blink = 0;
      m_armed = 0; m_sil = 0; m_pm = 0; m_pi = 0;
      return;
    end
    mev = bus.btn_mode && !m_pm;
    iev = bus.btn_inc && !m_pi && !mev;
    m_pm = bus.btn_mode;
    m_pi = bus.btn_inc;
    al_now = model_alarm();
    old_min = (m_t / 60) % 60;
    if (m_st == 0) begin
      if (m_run_cyc % TD == TD - 1) m_t = (m_t + 1) % 86400;
      m_run_cyc++;
    end
    h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
    if (iev) begin
      case (m_st)
        0: if (al_now) m_sil = 1;
        1: h = (h + 1) % 24;
        2: mi = (mi + 1) % 60;
        3: s = 0;
        4: m_ah = (m_ah + 1) % 24;
        default: m_am = (m_am + 1) % 60;
      endcase
    end
    m_t = h * 3600 + mi * 60 + s;
    if (mi != old_min) m_sil = 0;
    if (mev) begin
      if (m_st == 5) m_armed = 1;
      m_st = (m_st + 1) % NSt;
      m_run_cyc = 0;
      m_set_cyc = 0;
      m_blink = 0;
    end else if (m_st != 0) begin
      m_set_cyc++;
      m_blink = (m_set_cyc / BD) % 2;
    end
  endtask

  always begin
    logic [24:0] got_v, exp_v;
    int h, mi, s;
    @(posedge clk);
    model_step();
    #1;
    h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
    got_v = {bus.hr_u, bus.hr_t, bus.min_u, bus.min_t, bus.sec_u, bus.sec_t,
             bus.mode, bus.blink, bus.alarm};
    exp_v = {4'(h % 10), 2'(h / 10), 4'(mi % 10), 3'(mi / 10), 4'(s % 10), 3'(s / 10),
             3'(m_st), 1'(m_blink), model_alarm()};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL model_compare t=%0t got=%h want=%h", $time, got_v, exp_v);
    end
  end

  function automatic int dut_hr();
    return int'(bus.hr_t) * 10 + int'(bus.hr_u);
  endfunction
  function automatic int dut_min();
    return int'(bus.min_t) * 10 + int'(bus.min_u);
  endfunction
  function automatic int dut_secs();
    return dut_hr() * 3600 + dut_min() * 60 + int'(bus.sec_t) * 10 + int'(bus.sec_u);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_mode_n(input int n);
    repeat (n) begin
      @(negedge clk); bus.btn_mode = 1'b1;
      @(negedge clk); bus.btn_mode = 1'b0;
    end
  endtask
  task automatic press_inc_n(input int n);
    repeat (n) begin
      @(negedge clk); bus.btn_inc = 1'b1;
      @(negedge clk); bus.btn_inc = 1'b0;
    end
  endtask
  task automatic do_reset();
    @(negedge clk); aclr = 1'b1;
    @(negedge clk); aclr = 1'b0;
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    aclr = 1'b1;
    cycles(2);
    chk("reset_time", dut_secs(), 0);
    chk("reset_mode", int'(bus.mode), 0);
    chk("reset_blink", int'(bus.blink), 0);
    chk("reset_alarm", int'(bus.alarm), 0);
    aclr = 1'b0;

    // Preload 23:59 with seconds cleared, run to 23:59:58, then 8 more cycles to midnight.
    press_mode_n(1); press_inc_n(23);
    press_mode_n(1); press_inc_n(59);
    press_mode_n(1); press_inc_n(1);
    press_mode_n(NSt - 3);
    chk("run_entered", int'(bus.mode), 0);
    cycles(232);
    chk("preload_235958", dut_secs(), 23 * 3600 + 59 * 60 + 58);
    cycles(7);
    chk("before_wrap", dut_secs(), 23 * 3600 + 59 * 60 + 59);
    cycles(1);
    chk("midnight_wrap", dut_secs(), 0);

    // Minute wrap without hour carry, and a held inc counts once.
    press_mode_n(1); press_inc_n(5);
    press_mode_n(1); press_inc_n(59);
    chk("min_at_59", dut_min(), 59);
    press_inc_n(1);
    chk("min_wrap", dut_min(), 0);
    chk("min_wrap_hr", dut_hr(), 5);
    @(negedge clk); bus.btn_inc = 1'b1;
    cycles(20); bus.btn_inc = 1'b0;
    chk("held_inc_once", dut_min(), 1);

    // Coincident mode and inc in SET_HH: mode wins, hours untouched.
    press_mode_n(NSt - 1);
    chk("in_set_hh", int'(bus.mode), 1);
    @(negedge clk); bus.btn_mode = 1'b1; bus.btn_inc = 1'b1;
    @(negedge clk); bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    chk("coincide_mode", int'(bus.mode), 2);
    chk("coincide_hr", dut_hr(), 5);

    // Blink period in SET_HH, cleared on entering RUN.
    do_reset();
    press_mode_n(1);
    for (int k = 0; k < 9; k++) begin
      chk("blink_seq", int'(bus.blink), (k / 3) % 2);
      cycles(1);
    end
    press_mode_n(NSt - 1);
    chk("blink_run_mode", int'(bus.mode), 0);
    chk("blink_run_zero", int'(bus.blink), 0);

    // Reset pulse while editing 12:34:00.
    do_reset();
    press_mode_n(1); press_inc_n(12);
    press_mode_n(1); press_inc_n(34);
    chk("pre_clr_time", dut_secs(), 12 * 3600 + 34 * 60);
    @(negedge clk); aclr = 1'b1;
    @(negedge clk); aclr = 1'b0;
    chk("clr_time", dut_secs(), 0);
    chk("clr_mode", int'(bus.mode), 0);
    chk("clr_blink", int'(bus.blink), 0);

`ifdef RTC_ALARM_EN
    // Alarm at 00:01 fires at 00:01:00 and an inc silences it.
    do_reset();
    press_mode_n(5); press_inc_n(1); press_mode_n(1);
    cycles(239);
    chk("alarm_pre", int'(bus.alarm), 0);
    cycles(1);
    chk("alarm_time", dut_secs(), 60);
    chk("alarm_on", int'(bus.alarm), 1);
    press_inc_n(1);
    chk("alarm_silenced", int'(bus.alarm), 0);
    cycles(237);
    chk("alarm_still_quiet", int'(bus.alarm), 0);
`endif

    // Random button and reset traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.btn_mode = ($urandom_range(0, 99) < 4);
      bus.btn_inc  = ($urandom_range(0, 99) < 35);
      aclr         = ($urandom_range(0, 999) < 3);
    end
    @(negedge clk);
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; aclr = 1'b0;
    cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_time_controller.md
RTC_TIME_CONTROLLER -- requirements
Module: rtc_time_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000: clk cycles per 1 s tick.
REQ-002 SHALL have parameter BLINK_DIV, default 12500000: clk cycles per blink toggle.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port aclr, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port btn_mode, input, 1: level, high = pressed, synchronous to clk.
REQ-006 SHALL have port btn_inc, input, 1: level, high = pressed, synchronous to clk.
REQ-007 SHALL have ports sec_u, min_u, hr_u, output, 4 each: BCD units digits.
REQ-008 SHALL have ports sec_t and min_t, output, 3 each, and port hr_t, output, 2: BCD tens digits.
REQ-009 SHALL have port mode, output, 3: current FSM state encoding.
REQ-010 SHALL have port blink, output, 1: display-blank strobe for the field being edited.
REQ-011 SHALL have port alarm, output, 1: alarm active.

Function
REQ-012 SHALL detect rising edges of btn_mode/btn_inc (press events); edge-to-action latency 1 cycle; a held button yields exactly one event.
REQ-013 SHALL generate an internal one-cycle tick when the prescaler equals TICK_DIV-1, then wrap the prescaler to 0.
REQ-014 SHALL implement FSM states RUN, SET_HH, SET_MM, SET_SS; a mode event advances RUN->SET_HH->SET_MM->SET_SS->RUN.
REQ-015 SHALL, in RUN, advance time by 1 s per tick, BCD-carried: sec 59->00 carries min, min 59->00 carries hr, 23:59:59->00:00:00.
REQ-016 SHALL, in SET_HH, increment hours on inc events, 23->00, without carry into any other field.
REQ-017 SHALL, in SET_MM, increment minutes on inc events, 59->00, without carry into hours.
REQ-018 SHALL, in SET_SS, clear seconds to 00 on an inc event.
REQ-019 SHALL hold the prescaler at 0 and ignore ticks in all SET states; on the SET_SS->RUN transition the first tick occurs exactly TICK_DIV cycles later.
REQ-020 SHALL give a mode event priority when mode and inc events coincide in the same cycle; that inc is discarded.
REQ-021 SHALL toggle blink every BLINK_DIV cycles in SET states, force blink=0 in RUN, and restart the blink counter on every state change.
REQ-022 SHALL never present non-BCD digits or hours >23 on outputs.

Reset
REQ-023 SHALL, while aclr=1, force time 00:00:00, mode=RUN, blink=0, alarm=0, prescaler, blink counter and edge-detect registers to 0.
REQ-024 SHALL abandon any SET state on aclr mid-operation, discarding any partially set fields.

Configuration
REQ-025 SHALL, with RTC_ALARM_EN defined, add states SET_AH and SET_AM (SET_SS->SET_AH->SET_AM->RUN) editing the alarm hour/minute with the REQ-016/017 rules; alarm_hh:mm resets to 00:00.
REQ-026 SHALL, with RTC_ALARM_EN, arm the alarm on leaving SET_AM (armed flag cleared by reset); assert alarm in RUN while armed and hh:mm equals alarm_hh:mm; an inc event while alarm=1 silences it until the minute changes.
REQ-027 SHALL, without RTC_ALARM_EN, keep the alarm port and tie it to 0, with SET_SS->RUN as in REQ-014.

Structure
REQ-028 SHALL place the mode state encoding and digit limit constants (23, 59, 9, 5) in shared package rtc_pkg.
REQ-029 SHALL implement the tick generator as sub-module rtc_prescaler (parameter DIV, inputs clk/aclr/hold, output tick).

Verification
REQ-030 SHALL cover: TICK_DIV=4, preload 23:59:58 via SET states, return to RUN -> after 8 cycles time reads 00:00:00.
REQ-031 SHALL cover: in SET_MM at 59, one inc event -> minutes 00, hours unchanged; btn_inc held 20 cycles -> exactly +1.
REQ-032 SHALL cover: mode and inc rising in the same cycle in SET_HH -> state SET_MM, hours unchanged.
REQ-033 SHALL cover: aclr pulse while in SET_MM with time 12:34:00 -> next cycle 00:00:00, RUN, blink=0.
REQ-034 SHALL cover: BLINK_DIV=3 in SET_HH -> blink toggles every 3 cycles; entering RUN -> blink=0 the next cycle.
REQ-035 SHALL cover, with RTC_ALARM_EN: alarm set to 00:01, run from 00:00:58 -> alarm=1 at 00:01:00; inc event -> alarm=0 until 00:02.
